if_fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC and issues in-order word fetches to instruction memory.

---
 rtl/if_fetch_stage.sv | 143 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the PC, issues in-order word fetches, buffers responses and drives IF/ID.
// Optional macro IF_FETCH_COUNT_EN enables the delivered-instruction counter on fetch_count.
`default_nettype none

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic [31:0] fetch_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW+1:0] DEPTH_C = (CW+2)'(FIFO_DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   rsp_pc;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic [CW+1:0] credits_used;
  logic [CW-1:0] outstanding_nxt;
  logic [31:0]   redirect_aligned;
  logic          req_fire;
  logic          drop;
  logic          push;
  logic          pop;
  logic          unused_redirect_bits;

  assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Dropped-but-still-in-flight requests hold a credit in both counters, which
  // keeps the memory from ever being able to overrun the buffer.
  assign credits_used = {2'b00, fifo_count} + {2'b00, outstanding} + {2'b00, drop_cnt};

  assign imem_req_valid = !reset && !flush && (credits_used < DEPTH_C);
  assign imem_addr      = pc_q;

  assign req_fire        = imem_req_valid && imem_req_ready;
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  assign drop            = imem_rsp_valid && (drop_cnt != '0);
  assign push            = imem_rsp_valid && (drop_cnt == '0) && !flush;
  assign pop             = !flush && !stall && (fifo_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      rsp_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (flush) begin
        pc_q       <= redirect_aligned;
        rsp_pc     <= redirect_aligned;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        drop_cnt   <= outstanding_nxt;
      end else begin
        if (req_fire) pc_q <= pc_q + 32'd4;
        if (drop)     drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction_out <= NOP_INSTR;
      pc_out          <= 32'h0;
      instr_valid     <= 1'b0;
    end else if (flush) begin
      instruction_out <= NOP_INSTR;
      pc_out          <= 32'h0;
      instr_valid     <= 1'b0;
    end else if (!stall) begin
      if (pop) begin
        instruction_out <= fifo_data[rd_ptr];
        pc_out          <= fifo_pc[rd_ptr];
        instr_valid     <= 1'b1;
      end else begin
        instruction_out <= NOP_INSTR;
        instr_valid     <= 1'b0;
      end
    end
  end

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 32'h0;
    end else if (pop) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a latency-configurable memory model feeds responses;
// expected {pc,word} pairs are queued at each request handshake and checked at delivery.
`default_nettype none

module tb_if_fetch_stage;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .instr_valid     (instr_valid),
    .fetch_count     (fetch_count)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } mem_ent_t;

  mem_ent_t    memq[$];
  logic [63:0] sbq[$];

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 1;
  int          delivered = 0;
  logic [31:0] model_pc = 32'h0;
  logic        last_req;
  logic        expect_first = 1'b0;
  logic [31:0] expect_first_pc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, observe request, clock, then check outputs.
  task automatic tick(input logic st, input logic fl, input logic [31:0] rpc, input logic rdy);
    logic        hs;
    logic [31:0] a;
    logic [31:0] snap_instr;
    logic [31:0] snap_pc;
    logic        snap_valid;
    logic [63:0] s;
    mem_ent_t    e;
    logic [31:0] exp_cnt;
    snap_instr = instruction_out;
    snap_pc    = pc_out;
    snap_valid = instr_valid;
    stall          = st;
    flush          = fl;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    imem_rsp_valid = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rsp_data  = imem_rsp_valid ? memq[0].data : 32'h0;
    #1;
    hs       = imem_req_valid && rdy;
    last_req = imem_req_valid;
    a        = imem_addr;
    if (fl) check_eq("req_in_flush", {31'h0, imem_req_valid}, 32'h0);
    if (imem_req_valid) check_eq("req_addr", imem_addr, model_pc);
    @(posedge clk);
    @(negedge clk);
    if (imem_rsp_valid) void'(memq.pop_front());
    if (hs) begin
      e.data = mem_word(a);
      e.due  = cyc + lat;
      memq.push_back(e);
      sbq.push_back({a, mem_word(a)});
      model_pc = a + 32'd4;
    end
    if (fl) begin
      sbq.delete();
      model_pc = {rpc[31:2], 2'b00};
      check_eq("flush_instr", instruction_out, NOP);
      check_eq("flush_pc", pc_out, 32'h0);
      check_eq("flush_valid", {31'h0, instr_valid}, 32'h0);
    end else if (st) begin
      check_eq("stall_instr", instruction_out, snap_instr);
      check_eq("stall_pc", pc_out, snap_pc);
      check_eq("stall_valid", {31'h0, instr_valid}, {31'h0, snap_valid});
    end else if (instr_valid) begin
      delivered++;
      if (sbq.size() == 0) begin
        check_eq("unexpected_delivery", pc_out, 32'hFFFF_FFFF);
      end else begin
        s = sbq.pop_front();
        check_eq("deliver_pc", pc_out, s[63:32]);
        check_eq("deliver_instr", instruction_out, s[31:0]);
      end
      if (expect_first) begin
        check_eq("first_after_flush", pc_out, expect_first_pc);
        expect_first = 1'b0;
      end
    end else begin
      check_eq("bubble_instr", instruction_out, NOP);
      check_eq("bubble_pc_hold", pc_out, snap_pc);
    end
`ifdef IF_FETCH_COUNT_EN
    exp_cnt = 32'(delivered);
`else
    exp_cnt = 32'h0;
`endif
    check_eq("fetch_count", fetch_count, exp_cnt);
    cyc++;
  endtask

  initial begin
    int d0;
    reset          = 1'b1;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_instr", instruction_out, NOP);
    check_eq("rst_pc", pc_out, 32'h0);
    check_eq("rst_valid", {31'h0, instr_valid}, 32'h0);
    check_eq("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check_eq("rst_fetch_count", fetch_count, 32'h0);
    reset = 1'b0;

    // Streaming: first valid after the third edge, then one per cycle.
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("t1_c1_valid", {31'h0, instr_valid}, 32'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("t1_c2_valid", {31'h0, instr_valid}, 32'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("t1_c3_valid", {31'h0, instr_valid}, 32'h1);
    check_eq("t1_c3_pc", pc_out, 32'h0);
    d0 = delivered;
    repeat (8) tick(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("t1_throughput", 32'(delivered - d0), 32'd8);

    // Stall until credits run out, then release.
    repeat (5) tick(1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("t2_credit_stop", {31'h0, last_req}, 32'h0);
    repeat (8) tick(1'b0, 1'b0, 32'h0, 1'b1);

    // Longer memory latency so stale responses are still in flight at flush.
    lat = 3;
    repeat (4) tick(1'b0, 1'b0, 32'h0, 1'b1);
    expect_first    = 1'b1;
    expect_first_pc = 32'h100;
    tick(1'b0, 1'b1, 32'h100, 1'b1);
    repeat (14) tick(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("t3_first_seen", {31'h0, expect_first}, 32'h0);

    // Flush and stall together: flush wins.
    lat = 1;
    repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b1);
    expect_first    = 1'b1;
    expect_first_pc = 32'h204;
    tick(1'b1, 1'b1, 32'h206, 1'b1);
    repeat (8) tick(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("t4_first_seen", {31'h0, expect_first}, 32'h0);

    // Memory not ready: request must stay asserted with a stable address.
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      if (k >= 1) check_eq("t5_req_hold", {31'h0, last_req}, 32'h1);
    end
    check_eq("t5_bubble_valid", {31'h0, instr_valid}, 32'h0);
    repeat (10) tick(1'b0, 1'b0, 32'h0, 1'b1);

    // Drain with requests blocked; bounded.
    for (int k = 0; k < 20 && (sbq.size() > 0 || memq.size() > 0); k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0);
    end
    check_eq("drain_empty", 32'(sbq.size()), 32'h0);
`ifdef IF_FETCH_COUNT_EN
    check_eq("final_fetch_count", fetch_count, 32'(delivered));
`else
    check_eq("final_fetch_count", fetch_count, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
